prpg_seq_ctrl: RTL

Sequencer for the team's n-bit LFSR pattern generator (PRPG).
- Accepts a start command with a seed and a pattern count.
- Loads the seed into the PRPG, then steps it once per accepted pattern.
- Forwards each PRPG state to a downstream consumer over a valid/ready handshake.
- Accumulates the total number of 1 bits emitted and reports completion.
- Sits between a test/BIST control source and the PRPG instance; the PRPG keeps its polynomial, this block owns when it loads and shifts.

---
 rtl/prpg_seq_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/prpg_seq_ctrl.sv
// prpg_seq_ctrl: load/step sequencer for an N-bit PRPG with valid/ready pattern output and popcount total.
// Optional PRPG_PERIOD_CHK_EN: end the run early when the PRPG wraps back to its seed.
module prpg_seq_ctrl #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  seed_in,
    input  logic [CW-1:0] pat_count,
    input  logic [N-1:0]  prpg_q,
    output logic          prpg_load,
    output logic [N-1:0]  prpg_seed,
    output logic          prpg_shift,
    output logic          pat_valid,
    input  logic          pat_ready,
    output logic [N-1:0]  pat_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW+4:0] ones_total,
    output logic          period_hit
);
    localparam int PW = CW + 5;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] sent;
    logic [PW-1:0] pop;
    logic          run;
    logic          wrap;
    logic          xfer;

    assign run = state == RUN;
`ifdef PRPG_PERIOD_CHK_EN
    // A wrap is only meaningful once the seed itself has been emitted.
    assign wrap = run && sent != '0 && prpg_q == prpg_seed;
`else
    assign wrap = 1'b0;
`endif
    assign pat_valid  = run && !wrap;
    assign pat_data   = run ? prpg_q : '0;
    assign xfer       = pat_valid && pat_ready && !abort;
    assign prpg_shift = xfer;
    assign prpg_load  = state == LOAD && !abort;
    assign done       = state == DONE && !abort;
    assign busy       = state != IDLE;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) pop = pop + PW'(prpg_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prpg_seed  <= '0;
            cnt_r      <= '0;
            sent       <= '0;
            ones_total <= '0;
            err        <= 1'b0;
            period_hit <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    prpg_seed  <= seed_in;
                    cnt_r      <= pat_count;
                    sent       <= '0;
                    ones_total <= '0;
                    err        <= seed_in == '0;
                    period_hit <= 1'b0;
                    state      <= (seed_in == '0 || pat_count == '0) ? DONE : LOAD;
                end
                LOAD: state <= abort ? IDLE : RUN;
                RUN: begin
                    if (abort) state <= IDLE;
                    else if (wrap) begin
                        period_hit <= 1'b1;
                        state      <= DONE;
                    end else if (xfer) begin
                        sent       <= sent + CW'(1);
                        ones_total <= ones_total + pop;
                        if (sent == cnt_r - CW'(1)) state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
